// File: rtl/ram_arbiter_if.sv
// rtl/ram_arbiter_if.sv - Request-side and RAM-side signal bundle for ram_arbiter.
interface ram_arbiter_if #(
  parameter int ADDR_W = 32
) ();
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [ADDR_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [ADDR_W-1:0] dstore;
  logic              dwait;
  logic [ADDR_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [ADDR_W-1:0] ramstore;
  logic [ADDR_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              arb_err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, arb_err
  );
endinterface

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - Instruction/data arbiter for a single RAM port with timeout.
// Optional round-robin tie-breaking is enabled by defining RAM_ARB_RR_EN.
module ram_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input logic           CLK,
  input logic           nRST,
  ram_arbiter_if.master bus
);
  typedef enum logic [1:0] {IDLE, ISERV, DSERV} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;
  localparam logic [7:0] CNT_LAST   = 8'(TIMEOUT - 1);

  state_t     state, next_state;
  logic [7:0] cnt, next_cnt;
  logic       i_req, d_req, active, ok, err, done, d_wins;
  state_t     arb;

  assign i_req  = bus.iREN;
  assign d_req  = bus.dREN | bus.dWEN;
  assign active = (state == ISERV) ? i_req : (state == DSERV) ? d_req : 1'b0;
  assign ok     = active && (bus.ramstate == RAM_ACCESS);
  assign err    = active && !ok && ((bus.ramstate == RAM_ERROR) || (cnt == CNT_LAST));
  assign done   = ok | err;

`ifdef RAM_ARB_RR_EN
  logic last_d, last_d_eff;

  // The requester finishing this cycle already counts as last granted for
  // the arbitration that picks its successor.
  assign last_d_eff = done ? (state == DSERV) : last_d;
  assign d_wins     = !last_d_eff;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      last_d <= 1'b0;
    end else if (done) begin
      last_d <= (state == DSERV);
    end
  end
`else
  assign d_wins = 1'b1;
`endif

  assign arb = (d_req && (!i_req || d_wins)) ? DSERV : (i_req ? ISERV : IDLE);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
    end
  end

  always_comb begin
    next_state = state;
    next_cnt   = cnt + 8'd1;
    if (state == IDLE || !active || done) begin
      next_state = arb;
      next_cnt   = 8'd0;
    end
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iwait    = bus.iREN;
    bus.dwait    = d_req;
    bus.iload    = bus.ramload;
    bus.dload    = bus.ramload;
    bus.arb_err  = err;
    case (state)
      ISERV: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iwait   = bus.iREN & ~done;
      end
      DSERV: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dwait    = d_req & ~done;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - Self-checking bench for ram_arbiter against a behavioural model.
`timescale 1ns/1ps
module tb_ram_arbiter;
  localparam int TO = 4;

  logic CLK = 1'b0;
  logic nRST;
  int   total = 0;
  int   bad   = 0;

  ram_arbiter_if #(.ADDR_W(32)) bus ();

  ram_arbiter #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  // Model: who holds the RAM (0 none, 1 instruction, 2 data) and for how long.
  int   grant;
  int   served;
  bit   last_d;
  bit   m_done;
  logic [31:0] o_addr;
  logic o_ren, o_wen, o_iwait, o_dwait, o_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit i, input bit d, input bit last_was_d);
`ifdef RAM_ARB_RR_EN
    if (i && d) return last_was_d ? 1 : 2;
`else
    if (i && d) return 2;
`endif
    if (d) return 2;
    if (i) return 1;
    return 0;
  endfunction

  task automatic model_check();
    bit i, d, act, ok, er;
    i   = bus.iREN;
    d   = bus.dREN | bus.dWEN;
    act = (grant == 1) ? i : (grant == 2) ? d : 1'b0;
    ok  = act && bus.ramstate == 2'd2;
    er  = act && !ok && (bus.ramstate == 2'd3 || served == TO - 1);
    m_done = ok || er;
    chk("ramREN", bus.ramREN, (grant == 1) ? i : (grant == 2) ? (bus.dREN & ~bus.dWEN) : 1'b0);
    chk("ramWEN", bus.ramWEN, (grant == 2) ? bus.dWEN : 1'b0);
    chk("ramaddr", bus.ramaddr, (grant == 1) ? bus.iaddr : (grant == 2) ? bus.daddr : 32'h0);
    chk("ramstore", bus.ramstore, (grant == 2) ? bus.dstore : 32'h0);
    chk("iwait", bus.iwait, i && !(grant == 1 && m_done));
    chk("dwait", bus.dwait, d && !(grant == 2 && m_done));
    chk("arb_err", bus.arb_err, er);
    chk("iload", bus.iload, bus.ramload);
    chk("dload", bus.dload, bus.ramload);
    o_addr = bus.ramaddr; o_ren = bus.ramREN; o_wen = bus.ramWEN;
    o_iwait = bus.iwait; o_dwait = bus.dwait; o_err = bus.arb_err;
  endtask

  task automatic model_step();
    bit i, d, act, lw;
    i   = bus.iREN;
    d   = bus.dREN | bus.dWEN;
    act = (grant == 1) ? i : (grant == 2) ? d : 1'b0;
    if (!nRST) begin
      grant = 0; served = 0; last_d = 0;
    end else if (grant == 0 || !act || m_done) begin
      lw = m_done ? (grant == 2) : last_d;
      if (m_done) last_d = lw;
      grant  = pick(i, d, lw);
      served = 0;
    end else begin
      served++;
    end
  endtask

  task automatic cyc(input bit i, input logic [31:0] ia, input bit d, input bit w,
                     input logic [31:0] da, input logic [31:0] ds,
                     input logic [1:0] st, input logic [31:0] ld);
    bus.iREN = i; bus.iaddr = ia; bus.dREN = d; bus.dWEN = w;
    bus.daddr = da; bus.dstore = ds; bus.ramstate = st; bus.ramload = ld;
    #1;
    model_check();
    @(posedge CLK);
    model_step();
    @(negedge CLK);
  endtask

  initial begin
    logic [31:0] rr_addr [4];
    logic [31:0] exp_addr [4];
    grant = 0; served = 0; last_d = 0; m_done = 0;
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.dREN = 0; bus.dWEN = 0;
    bus.daddr = 0; bus.dstore = 0; bus.ramstate = 0; bus.ramload = 0;
    @(negedge CLK);
    // Held request during reset: outputs idle, iwait follows the request.
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    chk("rst_iwait", o_iwait, 1'b1);
    chk("rst_ren", o_ren, 1'b0);
    cyc(0, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    nRST = 1'b1;

    // Instruction read: BUSY twice then ACCESS.
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    chk("i1_ren", o_ren, 1'b1);
    chk("i1_addr", o_addr, 32'h40);
    chk("i1_wait_busy", o_iwait, 1'b1);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd1, 0);
    cyc(1, 32'h40, 0, 0, 0, 0, 2'd2, 32'h8C010004);
    chk("i1_wait_done", o_iwait, 1'b0);
    cyc(0, 32'h40, 0, 0, 0, 0, 2'd0, 0);
    cyc(0, 32'h40, 0, 0, 0, 0, 2'd0, 0);

    // Simultaneous I read and D write: data first, then instruction.
    cyc(1, 32'h44, 1, 1, 32'h100, 32'hDEADBEEF, 2'd0, 0);
    cyc(1, 32'h44, 1, 1, 32'h100, 32'hDEADBEEF, 2'd1, 0);
    chk("w_wen", o_wen, 1'b1);
    chk("w_addr", o_addr, 32'h100);
    chk("w_iwait", o_iwait, 1'b1);
    cyc(1, 32'h44, 1, 1, 32'h100, 32'hDEADBEEF, 2'd2, 0);
    chk("w_dwait_done", o_dwait, 1'b0);
    chk("w_iwait_done", o_iwait, 1'b1);
    cyc(1, 32'h44, 0, 0, 32'h100, 32'hDEADBEEF, 2'd0, 0);
    cyc(1, 32'h44, 0, 0, 32'h100, 32'hDEADBEEF, 2'd1, 0);
    chk("r_after_w_ren", o_ren, 1'b1);
    chk("r_after_w_addr", o_addr, 32'h44);
    cyc(1, 32'h44, 0, 0, 0, 0, 2'd2, 32'h1234);
    chk("r_after_w_done", o_iwait, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Timeout with RAM stuck BUSY.
    cyc(0, 0, 1, 0, 32'h200, 0, 2'd1, 0);
    for (int k = 1; k < TO; k++) begin
      cyc(0, 0, 1, 0, 32'h200, 0, 2'd1, 0);
      chk("to_no_err", o_err, 1'b0);
    end
    cyc(0, 0, 1, 0, 32'h200, 0, 2'd1, 0);
    chk("to_err", o_err, 1'b1);
    chk("to_dwait", o_dwait, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // ERROR during a data read.
    cyc(0, 0, 1, 0, 32'h300, 0, 2'd0, 0);
    cyc(0, 0, 1, 0, 32'h300, 0, 2'd3, 0);
    chk("e_err", o_err, 1'b1);
    chk("e_dwait", o_dwait, 1'b0);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
    chk("e_idle_err", o_err, 1'b0);

    // Asynchronous reset in the middle of a data write.
    cyc(0, 0, 1, 1, 32'h400, 32'h55, 2'd0, 0);
    cyc(0, 0, 1, 1, 32'h400, 32'h55, 2'd1, 0);
    chk("ar_pre_wen", o_wen, 1'b1);
    nRST = 1'b0;
    #1;
    chk("ar_wen", bus.ramWEN, 1'b0);
    chk("ar_ren", bus.ramREN, 1'b0);
    chk("ar_dwait", bus.dwait, 1'b1);
    @(posedge CLK); model_step(); @(negedge CLK);
    nRST = 1'b1;
    cyc(0, 0, 1, 1, 32'h400, 32'h55, 2'd1, 0);
    chk("ar_rel_idle", o_wen, 1'b0);
    cyc(0, 0, 1, 1, 32'h400, 32'h55, 2'd1, 0);
    chk("ar_regrant", o_wen, 1'b1);
    cyc(0, 0, 1, 1, 32'h400, 32'h55, 2'd2, 0);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Both requests held, ACCESS every serve cycle: record the grant order.
    nRST = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);
    nRST = 1'b1;
    cyc(1, 32'h40, 1, 0, 32'h100, 0, 2'd2, 0);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 32'h40, 1, 0, 32'h100, 0, 2'd2, 0);
      rr_addr[k] = o_addr;
    end
`ifdef RAM_ARB_RR_EN
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h40; exp_addr[2] = 32'h100; exp_addr[3] = 32'h40;
`else
    exp_addr[0] = 32'h100; exp_addr[1] = 32'h100; exp_addr[2] = 32'h100; exp_addr[3] = 32'h100;
`endif
    for (int k = 0; k < 4; k++) chk($sformatf("order%0d", k), rr_addr[k], exp_addr[k]);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0,
          $urandom_range(0, 3) == 0, $urandom, $urandom,
          2'($urandom_range(0, 3) == 0 ? $urandom_range(2, 3) : $urandom_range(0, 1)),
          $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Two-requester arbiter that shares the single RAM port (cpu_ram_if signal set: ramREN/ramWEN/ramaddr/ramstore/ramload/ramstate) between instruction fetch and data access.
- Sits between the datapath request side and the RAM, replacing direct datapath-to-RAM wiring.
- Grants one requester at a time, holds the grant until RAM reports ACCESS, ERROR, or a timeout, and returns per-requester wait/load.

Parameters:
- TIMEOUT, 255, max cycles a grant is held without ACCESS/ERROR before abort (1..255; 8-bit counter).
- ADDR_W, 32, address/data width.

Ports:
- CLK  in  1  clock; all state on rising edge.
- nRST  in  1  asynchronous active-low reset.
- iREN  in  1  instruction read request (level, held until iwait low).
- iaddr  in  ADDR_W  instruction address.
- iwait  out  1  instruction stall.
- iload  out  ADDR_W  instruction read data.
- dREN  in  1  data read request.
- dWEN  in  1  data write request (dREN & dWEN both high = write).
- daddr  in  ADDR_W  data address.
- dstore  in  ADDR_W  data write value.
- dwait  out  1  data stall.
- dload  out  ADDR_W  data read data.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  ADDR_W  RAM address.
- ramstore  out  ADDR_W  RAM write data.
- ramload  in  ADDR_W  RAM read data.
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
- arb_err  out  1  one-cycle pulse on ERROR or timeout completion.

Behaviour:
- Reset (nRST low, async):
  - state=IDLE, timeout counter=0, last-grant=I.
  - ramREN=ramWEN=0, ramaddr=ramstore=0, arb_err=0.
  - iwait=iREN and dwait=(dREN|dWEN); both are combinational, so a held request stays stalled through reset.
- States: IDLE, ISERV, DSERV; state and counter are registered.
- IDLE:
  - RAM enables low, ramaddr/ramstore=0.
  - Next state: DSERV if dREN|dWEN, else ISERV if iREN, else IDLE.
  - Fixed priority: data over instruction.
- ISERV:
  - ramREN=1, ramWEN=0, ramaddr=iaddr.
- DSERV:
  - ramWEN=dWEN, ramREN=dREN&~dWEN, ramaddr=daddr, ramstore=dstore.
- iload=ramload and dload=ramload at all times; valid only in the completion cycle.
- Completion: in a serve state when ramstate==ACCESS.
  - The served wait drops low for exactly that cycle.
  - Next state is chosen by the same arbitration as IDLE (back-to-back allowed, no idle bubble).
  - Counter clears.
- ERROR in a serve state:
  - Served wait drops low that cycle, arb_err=1, load data undefined.
  - Next state by arbitration; counter clears.
- Timeout:
  - Counter increments each serve cycle without ACCESS/ERROR.
  - When counter==TIMEOUT-1 and no ACCESS, treat as ERROR completion (wait low, arb_err pulse).
- Request withdrawn mid-service (served request low):
  - RAM enables drop combinationally.
  - Next state by arbitration; no arb_err, counter clears.
- Non-served wait = its request, held high throughout.
- Latency: request in IDLE → RAM enable 1 cycle later → wait low in the ACCESS cycle. Minimum 2 cycles from request to completion.
- Simultaneous I and D request in IDLE: D is served first; I is served next, immediately after D's completion cycle.

Optional Feature:
- Macro RAM_ARB_RR_EN.
- Defined:
  - Round-robin arbitration; a last-grant register updates on each completion.
  - With both requesting, the requester not last granted wins.
  - From reset, last-grant=I, so D wins the first tie.
- Undefined: fixed data priority; no last-grant register.

Test Plan:
- iREN=1, iaddr=0x40, ramstate BUSY 2 cycles then ACCESS with ramload=0x8C010004:
  - ramREN=1, ramaddr=0x40 from cycle 1.
  - iwait low only in the ACCESS cycle; iload=0x8C010004.
- iREN and dWEN together, daddr=0x100, dstore=0xDEADBEEF, ACCESS each on its 2nd serve cycle:
  - Write to 0x100 served first, then a read of iaddr with no IDLE gap.
  - iwait stays high during the data service.
- Held request with ramstate stuck BUSY, TIMEOUT=4:
  - Completes at serve cycle 4 with arb_err pulse and wait low; re-arbitrates next cycle.
- ramstate=ERROR during a dREN serve → dwait low and arb_err=1 for 1 cycle, then IDLE.
- nRST asserted mid-DSERV:
  - ramWEN/ramREN=0 immediately (asynchronous), state IDLE.
  - After release, the still-held request is re-granted one cycle later.
- With RAM_ARB_RR_EN, iREN and dREN held, each ACCESS after 1 cycle: grant order D, I, D, I. Without the macro: D repeatedly while dREN is held.
